// File: rtl/collision_event_handler_pkg.sv
// Shared game types and default constants for the collision event handler.
package game_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PLAY      = 2'd1,
    COOLDOWN  = 2'd2,
    GAME_OVER = 2'd3
  } game_state_t;

  localparam int LIVES_INIT_D      = 3;
  localparam int HART_POINTS_D     = 5;
  localparam int SCORE_W_D         = 8;
  localparam int COOLDOWN_FRAMES_D = 60;
  localparam int BLINK_FRAMES_D    = 4;

endpackage

// File: rtl/collision_event_handler_frame_down_counter.sv
// Loadable down-counter stepped by startOfFrame; done fires on the tick that reaches 0.
module frame_down_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  // Combinational so the owner can act in the same edge the count hits zero.
  assign done = tick && (count == WIDTH'(1));

endmodule

// File: rtl/collision_event_handler.sv
// Collision event handler: score, lives, cooldown and game state per qualified hit pulse.
// Optional macro COOLDOWN_BLINK_EN enables smiley blinking during cooldown.
module collision_event_handler
  import game_pkg::*;
#(
  parameter int LIVES_INIT      = LIVES_INIT_D,
  parameter int HART_POINTS     = HART_POINTS_D,
  parameter int SCORE_W         = SCORE_W_D,
  parameter int COOLDOWN_FRAMES = COOLDOWN_FRAMES_D,
  parameter int BLINK_FRAMES    = BLINK_FRAMES_D
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               SingleHitPulse,
  input  logic               hit_is_hart,
  input  logic               hit_is_number,
  input  logic               start_key,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         lives,
  output logic [1:0]         game_state,
  output logic               hart_taken,
  output logic               life_lost,
  output logic               smiley_visible
);

  localparam int CNT_W = $clog2(COOLDOWN_FRAMES + 1);

  game_state_t      state;
  logic             start_q;
  logic             start_pulse;
  logic             hit_hart;
  logic             hit_num;
  logic             in_play;
  logic             in_cool;
  logic             cool_load;
  logic             cool_done;
  logic [SCORE_W:0] score_sum;
  logic [SCORE_W-1:0] score_next;
  logic [2:0]       lives_dec;

  assign start_pulse = start_key && !start_q;
  assign hit_hart    = SingleHitPulse && hit_is_hart;
  assign hit_num     = SingleHitPulse && !hit_is_hart && hit_is_number;
  assign in_play     = (state == PLAY);
  assign in_cool     = (state == COOLDOWN);
  assign lives_dec   = lives - 3'd1;
  assign cool_load   = in_play && hit_num && (lives_dec != 3'd0);

  // One extra bit catches the carry so the score clamps instead of wrapping.
  assign score_sum  = {1'b0, score} + (SCORE_W + 1)'(HART_POINTS);
  assign score_next = score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];

  assign game_state = state;

  frame_down_counter #(.WIDTH(CNT_W)) u_cooldown (
    .clk        (clk),
    .resetN     (resetN),
    .load       (cool_load),
    .load_value (CNT_W'(COOLDOWN_FRAMES)),
    .tick       (startOfFrame && in_cool),
    .done       (cool_done)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state      <= IDLE;
      score      <= '0;
      lives      <= 3'd0;
      hart_taken <= 1'b0;
      life_lost  <= 1'b0;
      start_q    <= 1'b0;
    end else begin
      start_q    <= start_key;
      hart_taken <= 1'b0;
      life_lost  <= 1'b0;
      case (state)
        IDLE, GAME_OVER: begin
          if (start_pulse) begin
            score <= '0;
            lives <= 3'(LIVES_INIT);
            state <= PLAY;
          end
        end
        PLAY: begin
          if (hit_hart) begin
            score      <= score_next;
            hart_taken <= 1'b1;
          end else if (hit_num) begin
            life_lost <= 1'b1;
            lives     <= lives_dec;
            state     <= (lives_dec == 3'd0) ? GAME_OVER : COOLDOWN;
          end
        end
        COOLDOWN: begin
          if (hit_hart) begin
            score      <= score_next;
            hart_taken <= 1'b1;
          end
          if (cool_done) state <= PLAY;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef COOLDOWN_BLINK_EN
  localparam int BLINK_W = $clog2(BLINK_FRAMES + 1);

  logic blink_done;

  // Reloading on its own done makes the blink counter free-run with period BLINK_FRAMES.
  frame_down_counter #(.WIDTH(BLINK_W)) u_blink (
    .clk        (clk),
    .resetN     (resetN),
    .load       (cool_load || blink_done),
    .load_value (BLINK_W'(BLINK_FRAMES)),
    .tick       (startOfFrame && in_cool),
    .done       (blink_done)
  );

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      smiley_visible <= 1'b1;
    end else if (cool_load) begin
      smiley_visible <= 1'b0;
    end else if (cool_done) begin
      smiley_visible <= 1'b1;
    end else if (blink_done) begin
      smiley_visible <= !smiley_visible;
    end
  end
`else
  assign smiley_visible = 1'b1;
`endif

endmodule
